// File: rtl/ddr_burst_sequencer.sv
// DDR burst sequencer: per-bank open/closed tracking, RD/WR latency pipeline,
// and a one-column-per-clock burst engine with wrap, burst chop and auto-precharge.
module ddr_burst_sequencer #(
  parameter int RANKS     = 1,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int BC_OTF    = 1,
  parameter int CL        = 16,
  parameter int CWL       = 12,
  parameter int MAXLAT    = 32,
  localparam int NB       = 1 << (BGWIDTH + BAWIDTH),
  localparam int NBANKS   = RANKS * NB,
  localparam int RW       = (RANKS > 1) ? $clog2(RANKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [RANKS-1:0]     cs_n,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  input  logic [ADDRWIDTH-1:0] A,
  input  logic                 ACT,
  input  logic                 PR,
  input  logic                 PRA,
  input  logic                 RD,
  input  logic                 RDA,
  input  logic                 WR,
  input  logic                 WRA,
  output logic [NBANKS-1:0]    open_mask,
  output logic                 rd_en,
  output logic                 wr_en,
  output logic [RW-1:0]        beat_rank,
  output logic [BGWIDTH-1:0]   beat_bg,
  output logic [BAWIDTH-1:0]   beat_ba,
  output logic [COLWIDTH-1:0]  beat_col,
  output logic                 beat_last,
  output logic                 cmd_err
);

  localparam int IW  = $clog2(NBANKS);
  localparam int CW  = RW + BGWIDTH + BAWIDTH;
  localparam int LW  = $clog2(MAXLAT + 1);
  localparam int LBW = $clog2(BL);

  typedef struct packed {
    logic                valid;
    logic                rd;
    logic                ap;
    logic [RW-1:0]       rank;
    logic [BGWIDTH-1:0]  bg;
    logic [BAWIDTH-1:0]  ba;
    logic [COLWIDTH-1:0] col;
    logic                bc4;
  } entry_t;

  entry_t              pipe_q [MAXLAT];
  entry_t              pipe_d [MAXLAT];
  entry_t              new_e;
  logic [MAXLAT:0]     pipe_v;
  logic [RANKS-1:0]    sel;
  logic [RW-1:0]       cmd_rank;
  logic [IW-1:0]       cmd_idx, ap_idx;
  logic [LW-1:0]       lat_sel, ins_idx;
  logic [NBANKS-1:0]   open_d;
  logic                any_cmd, one_hot, cmd_ok, multi_err, is_rw, is_rd;
  logic                bank_open, ap_clr, ap_hit, slot_busy;
  logic                act_ok, act_err, rw_ok, rw_err;
  logic                burst_busy, start_ok, start_drop;
  logic                beat_ap, beat_bc4;
  logic [LBW-1:0]      beats_left;
  logic [COLWIDTH-1:0] wrap_mask, next_col;

  // Command strobes are single-cycle and sampled on the edge they are high;
  // there is no backpressure, so an unacceptable command is dropped with cmd_err.
  always_comb begin
    sel      = ~cs_n;
    any_cmd  = ACT | PR | PRA | RD | RDA | WR | WRA;
    one_hot  = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    cmd_ok   = any_cmd && one_hot;
    multi_err = any_cmd && (sel != '0) && !one_hot;
    cmd_rank = '0;
    for (int r = 0; r < RANKS; r++)
      if (sel[r]) cmd_rank = RW'(r);
    cmd_idx   = IW'(CW'({cmd_rank, bg, ba}));
    ap_idx    = IW'(CW'({beat_rank, beat_bg, beat_ba}));
    bank_open = open_mask[cmd_idx];
    ap_clr    = beat_last && beat_ap;
    ap_hit    = ap_clr && (ap_idx == cmd_idx);
    is_rd     = RD | RDA;
    is_rw     = is_rd | WR | WRA;
    lat_sel   = is_rd ? LW'(CL) : LW'(CWL);
    ins_idx   = lat_sel - 1'b1;
    pipe_v    = '0;
    for (int i = 0; i < MAXLAT; i++) pipe_v[i] = pipe_q[i].valid;
    // An entry one slot above the insert point would shift onto it this edge.
    slot_busy = pipe_v[lat_sel];
    act_ok    = cmd_ok && ACT && (!bank_open || ap_hit);
    act_err   = cmd_ok && ACT && bank_open && !ap_hit;
    rw_ok     = cmd_ok && is_rw && bank_open && !slot_busy;
    rw_err    = cmd_ok && is_rw && (!bank_open || slot_busy);
  end

  always_comb begin
    new_e.valid = 1'b1;
    new_e.rd    = is_rd;
    new_e.ap    = RDA | WRA;
    new_e.rank  = cmd_rank;
    new_e.bg    = bg;
    new_e.ba    = ba;
    new_e.col   = A[COLWIDTH-1:0];
    new_e.bc4   = (BC_OTF != 0) && !A[12];
    for (int i = 0; i < MAXLAT - 1; i++) pipe_d[i] = pipe_q[i+1];
    pipe_d[MAXLAT-1] = '0;
    if (rw_ok) pipe_d[ins_idx] = new_e;
  end

  // Ordering gives auto-precharge < PR/PRA < ACT priority on the same bank.
  always_comb begin
    open_d = open_mask;
    if (ap_clr) open_d[ap_idx] = 1'b0;
    if (cmd_ok && PR) open_d[cmd_idx] = 1'b0;
    if (cmd_ok && PRA)
      for (int b = 0; b < NBANKS; b++)
        if ((b / NB) == int'(cmd_rank)) open_d[b] = 1'b0;
    if (act_ok) open_d[cmd_idx] = 1'b1;
  end

  always_comb begin
    burst_busy = (rd_en | wr_en) && !beat_last;
    start_ok   = pipe_q[0].valid && !burst_busy;
    start_drop = pipe_q[0].valid && burst_busy;
    wrap_mask  = beat_bc4 ? COLWIDTH'(BL/2 - 1) : COLWIDTH'(BL - 1);
    next_col   = (beat_col & ~wrap_mask) | ((beat_col + 1'b1) & wrap_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAXLAT; i++) pipe_q[i] <= '0;
      open_mask  <= '0;
      cmd_err    <= 1'b0;
    end else begin
      for (int i = 0; i < MAXLAT; i++) pipe_q[i] <= pipe_d[i];
      open_mask  <= open_d;
      cmd_err    <= multi_err | act_err | rw_err | start_drop;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      beat_rank  <= '0;
      beat_bg    <= '0;
      beat_ba    <= '0;
      beat_col   <= '0;
      beat_last  <= 1'b0;
      beat_ap    <= 1'b0;
      beat_bc4   <= 1'b0;
      beats_left <= '0;
    end else if (start_ok) begin
      rd_en      <= pipe_q[0].rd;
      wr_en      <= !pipe_q[0].rd;
      beat_rank  <= pipe_q[0].rank;
      beat_bg    <= pipe_q[0].bg;
      beat_ba    <= pipe_q[0].ba;
      beat_col   <= pipe_q[0].col;
      beat_last  <= 1'b0;
      beat_ap    <= pipe_q[0].ap;
      beat_bc4   <= pipe_q[0].bc4;
      beats_left <= pipe_q[0].bc4 ? LBW'(BL/2 - 1) : LBW'(BL - 1);
    end else if (burst_busy) begin
      beat_col   <= next_col;
      beat_last  <= (beats_left == LBW'(1));
      beats_left <= beats_left - 1'b1;
    end else begin
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      beat_rank  <= '0;
      beat_bg    <= '0;
      beat_ba    <= '0;
      beat_col   <= '0;
      beat_last  <= 1'b0;
      beat_ap    <= 1'b0;
      beat_bc4   <= 1'b0;
      beats_left <= '0;
    end
  end

endmodule

// File: tb/tb_ddr_burst_sequencer.sv
// Directed bench for ddr_burst_sequencer with two ranks: latency, wrap/BC4,
// error pulses, back-to-back bursts, PRA, auto-precharge vs ACT, and mid-burst reset.
module tb_ddr_burst_sequencer;

  localparam logic [1:0] CS0 = 2'b10;
  localparam logic [1:0] CS1 = 2'b01;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cs_n;
  logic [1:0]  bg, ba;
  logic [16:0] A;
  logic        ACT, PR, PRA, RD, RDA, WR, WRA;
  logic [31:0] open_mask;
  logic        rd_en, wr_en, beat_rank, beat_last, cmd_err;
  logic [1:0]  beat_bg, beat_ba;
  logic [9:0]  beat_col;

  int errors = 0;
  int checks = 0;
  int seen;
  logic [9:0] exp_q[$];

  ddr_burst_sequencer #(.RANKS(2)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .bg(bg), .ba(ba), .A(A),
    .ACT(ACT), .PR(PR), .PRA(PRA), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA),
    .open_mask(open_mask), .rd_en(rd_en), .wr_en(wr_en), .beat_rank(beat_rank),
    .beat_bg(beat_bg), .beat_ba(beat_ba), .beat_col(beat_col),
    .beat_last(beat_last), .cmd_err(cmd_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver: presents one command for one edge
  task automatic cmd(input string kind, input logic [1:0] cs, input logic [1:0] g,
                     input logic [1:0] b, input logic [16:0] a);
    cs_n = cs; bg = g; ba = b; A = a;
    case (kind)
      "ACT": ACT = 1'b1;
      "PR":  PR  = 1'b1;
      "PRA": PRA = 1'b1;
      "RD":  RD  = 1'b1;
      "RDA": RDA = 1'b1;
      "WR":  WR  = 1'b1;
      "WRA": WRA = 1'b1;
      default: ;
    endcase
    tick();
    {ACT, PR, PRA, RD, RDA, WR, WRA} = '0;
    cs_n = 2'b11; A = '0; bg = '0; ba = '0;
  endtask

  // scoreboard: checks one beat per cycle from exp_q; stays on the final beat
  task automatic play_burst(input logic rd, input logic rk, input logic [1:0] g,
                            input logic [1:0] b, input int err_at);
    int n;
    logic [9:0] col;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      col = exp_q.pop_front();
      chk($sformatf("beat%0d", k),
          {rd_en, wr_en, beat_last, cmd_err, beat_rank, beat_bg, beat_ba, beat_col},
          {rd, !rd, (k == n - 1), (k == err_at), rk, g, b, col});
      if (k < n - 1) tick();
    end
  endtask

  task automatic watch_idle(input int n);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rd_en || wr_en) seen++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cs_n = 2'b11; bg = '0; ba = '0; A = '0;
    {ACT, PR, PRA, RD, RDA, WR, WRA} = '0;
    tick(3);
    chk("reset_outs", {open_mask, rd_en, wr_en, beat_last, cmd_err, beat_col}, '0);
    reset_n = 1'b1;
    tick();

    // ACT r0 bg1 ba2, RD col 0x10 BL8
    cmd("ACT", CS0, 2'd1, 2'd2, 17'h0);
    chk("act_mask", open_mask, 32'h0000_0040);
    chk("act_noerr", cmd_err, 1'b0);
    cmd("RD", CS0, 2'd1, 2'd2, 17'h1010);
    tick(15);
    chk("rd_before_cl", rd_en, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) exp_q.push_back(10'h010 + 10'(k));
    play_burst(1'b1, 1'b0, 2'd1, 2'd2, -1);
    tick();
    chk("rd_after_burst", {rd_en, beat_last}, 2'b00);

    // BC4 read with wrap, then WRA with auto-precharge
    cmd("RD", CS0, 2'd1, 2'd2, 17'h0006);
    tick(15);
    tick();
    exp_q = '{10'h006, 10'h007, 10'h004, 10'h005};
    play_burst(1'b1, 1'b0, 2'd1, 2'd2, -1);
    cmd("WRA", CS0, 2'd1, 2'd2, 17'h1008);
    tick(11);
    chk("wr_before_cwl", wr_en, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) exp_q.push_back(10'h008 + 10'(k));
    play_burst(1'b0, 1'b0, 2'd1, 2'd2, -1);
    chk("wra_open_during_last", open_mask, 32'h0000_0040);
    tick();
    chk("wra_closed", {open_mask, wr_en}, '0);

    // illegal commands
    cmd("RD", CS0, 2'd1, 2'd2, 17'h1000);
    chk("rd_closed_err", cmd_err, 1'b1);
    tick();
    chk("err_one_pulse", cmd_err, 1'b0);
    watch_idle(17);
    chk("rd_closed_no_burst", seen, 0);
    cmd("ACT", 2'b00, 2'd0, 2'd0, 17'h0);
    chk("multi_cs_err", {cmd_err, open_mask}, {1'b1, 32'h0});
    cmd("ACT", CS1, 2'd0, 2'd0, 17'h0);
    chk("act_r1", {cmd_err, open_mask}, {1'b0, 32'h0001_0000});
    cmd("ACT", CS1, 2'd0, 2'd0, 17'h0);
    chk("act_open_err", {cmd_err, open_mask}, {1'b1, 32'h0001_0000});
    cmd("ACT", 2'b11, 2'd1, 2'd1, 17'h0);
    chk("no_cs_ignored", {cmd_err, open_mask}, {1'b0, 32'h0001_0000});

    // two RDs 4 cycles apart: second dropped at its start
    cmd("RD", CS1, 2'd0, 2'd0, 17'h1000);
    tick(3);
    cmd("RD", CS1, 2'd0, 2'd0, 17'h1020);
    tick(11);
    chk("tccd_before", rd_en, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) exp_q.push_back(10'(k));
    play_burst(1'b1, 1'b1, 2'd0, 2'd0, 4);
    tick();
    chk("tccd_dropped", {rd_en, cmd_err}, 2'b00);
    watch_idle(6);
    chk("tccd_no_second", seen, 0);

    // two RDs 8 cycles apart: seamless 16 beats
    cmd("RD", CS1, 2'd0, 2'd0, 17'h1000);
    tick(7);
    cmd("RD", CS1, 2'd0, 2'd0, 17'h1018);
    tick(7);
    chk("seam_before", rd_en, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) exp_q.push_back(10'(k));
    play_burst(1'b1, 1'b1, 2'd0, 2'd0, -1);
    tick();
    for (int k = 0; k < 8; k++) exp_q.push_back(10'h018 + 10'(k));
    play_burst(1'b1, 1'b1, 2'd0, 2'd0, -1);
    tick();
    chk("seam_end", rd_en, 1'b0);

    // PRA rank1 with 5 rank1 banks and 2 rank0 banks open
    cmd("ACT", CS1, 2'd0, 2'd1, 17'h0);
    cmd("ACT", CS1, 2'd1, 2'd0, 17'h0);
    cmd("ACT", CS1, 2'd2, 2'd3, 17'h0);
    cmd("ACT", CS1, 2'd3, 2'd3, 17'h0);
    cmd("ACT", CS0, 2'd0, 2'd0, 17'h0);
    cmd("ACT", CS0, 2'd3, 2'd1, 17'h0);
    chk("seven_open", open_mask, 32'h8813_2001);
    cmd("PRA", CS1, 2'd0, 2'd0, 17'h0);
    chk("pra_r1", {cmd_err, open_mask}, {1'b0, 32'h0000_2001});
    cmd("PR", CS1, 2'd0, 2'd0, 17'h0);
    chk("pr_closed_legal", {cmd_err, open_mask}, {1'b0, 32'h0000_2001});
    cmd("PR", CS0, 2'd3, 2'd1, 17'h0);
    chk("pr_r0", open_mask, 32'h0000_0001);

    // RDA finishing while ACT hits the same bank: bank stays open
    cmd("RDA", CS0, 2'd0, 2'd0, 17'h1000);
    tick(16);
    for (int k = 0; k < 8; k++) exp_q.push_back(10'(k));
    play_burst(1'b1, 1'b0, 2'd0, 2'd0, -1);
    cmd("ACT", CS0, 2'd0, 2'd0, 17'h0);
    chk("ap_vs_act", {cmd_err, open_mask}, {1'b0, 32'h0000_0001});
    tick();
    chk("ap_vs_act_hold", open_mask, 32'h0000_0001);

    // reset on the 3rd beat of a read
    cmd("RD", CS0, 2'd0, 2'd0, 17'h1000);
    tick(16);
    tick(2);
    chk("third_beat", {rd_en, beat_col}, {1'b1, 10'h002});
    reset_n = 1'b0;
    #1;
    chk("midburst_reset", {open_mask, rd_en, wr_en, beat_last, cmd_err, beat_col}, '0);
    tick(2);
    reset_n = 1'b1;
    watch_idle(20);
    chk("no_beats_after_reset", seen, 0);
    chk("mask_after_reset", open_mask, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_burst_sequencer.md
Name: ddr_burst_sequencer

Overview:
- Multi-rank successor to the per-bank row/column tracking and read-enable logic in the DIMM model.
- Tracks the open/closed state of every bank and delays RD/WR by the configured read/write latency.
- Plays out each burst one column per clk, with wrap-within-burst addressing and BL8/BC4 on-the-fly.
- Drives data-path enables and handles auto-precharge. Sits between the command decoder and the chip/cache instances.

Parameters:
- RANKS, 1, number of ranks (one cs_n bit each).
- BGWIDTH, 2, bank-group address width.
- BAWIDTH, 2, bank address width.
- ADDRWIDTH, 17, row address width.
- COLWIDTH, 10, column address width.
- BL, 8, burst length in beats; power of two, ≥4.
- BC_OTF, 1, 1 enables burst-chop-on-the-fly: A12 low on RD/WR gives BL/2 beats.
- CL, 16, RD-to-first-read-beat latency in clk cycles, 1..MAXLAT.
- CWL, 12, WR-to-first-write-beat latency in clk cycles, 1..MAXLAT.
- MAXLAT, 32, depth of the latency pipeline.

Ports:
- clk  in  1  emulation clock (ck_t gated by cke)
- reset_n  in  1  asynchronous active-low reset
- cs_n  in  RANKS  chip selects, active low
- bg  in  BGWIDTH  bank group of the current command
- ba  in  BAWIDTH  bank of the current command
- A  in  ADDRWIDTH  address; row on ACT; column [COLWIDTH-1:0] and A12 (BC_n) on RD/WR
- ACT, PR, PRA, RD, RDA, WR, WRA  in  1 each  decoded single-cycle command strobes
- open_mask  out  RANKS*2^(BGWIDTH+BAWIDTH)  1 = bank open; index = rank*NB + bg*2^BAWIDTH + ba
- rd_en  out  1  read beat active (dq output enable)
- wr_en  out  1  write beat active (capture dq)
- beat_rank  out  max(1,$clog2(RANKS))  rank of the current beat
- beat_bg  out  BGWIDTH  bank group of the current beat
- beat_ba  out  BAWIDTH  bank of the current beat
- beat_col  out  COLWIDTH  column of the current beat
- beat_last  out  1  final beat of the burst
- cmd_err  out  1  one-cycle pulse on an illegal or dropped command

Behaviour:
- Async reset clears open_mask, the latency pipeline, the burst engine, and all outputs to 0.
- A reset mid-burst aborts the burst; no auto-precharge is performed.
- Rank select:
  - A command is considered only if exactly one cs_n bit is low; that bit selects the rank.
  - All cs_n high: the command is ignored, no error.
  - More than one cs_n low: cmd_err, command ignored.
- ACT:
  - Sets the addressed open_mask bit on the next clk.
  - ACT to an already-open bank: cmd_err, no change.
- PR clears the addressed bank bit. PRA clears all bank bits of the selected rank. Precharging a closed bank is legal.
- RD/RDA/WR/WRA to a closed bank: cmd_err, command dropped.
- Accepted RD/WR:
  - Pushes an entry {rd/wr, ap, rank, bg, ba, col, bc4} into the latency pipeline.
  - bc4 = BC_OTF && !A[12]; beats = bc4 ? BL/2 : BL.
  - First beat appears exactly CL (read) or CWL (write) cycles after the command cycle: the command is sampled at edge t, and rd_en/wr_en go high after edge t+CL / t+CWL.
- Burst engine:
  - One beat per clk for the burst's beat count; beat_last is asserted on the final beat.
  - Column order wraps within a BL-aligned block: low log2(BL) bits increment modulo BL (modulo BL/2 for bc4), upper bits are held.
  - Example: start col 0x06, BL8 → 6,7,0,1,2,3,4,5.
- Back-to-back bursts:
  - A burst whose start lands the cycle after a beat_last continues seamlessly.
  - A burst whose start lands while another is active (tCCD violation, or RD/WR turnaround overlap) is dropped and cmd_err pulses on that start cycle. The active burst is unaffected.
- Auto-precharge: RDA/WRA clear their bank's open_mask bit on the cycle after beat_last.
- Simultaneous events in one cycle:
  - Auto-precharge clear plus ACT to the same bank: the ACT wins and the bank stays open.
  - Auto-precharge clear plus PR: the bank ends closed.
- A PR to a bank with a burst in flight is legal; the burst still completes.
- Pipeline entries carry their own timing, so several commands may be in flight; no backpressure.

Test Plan:
- ACT rank0 bg1 ba2; RD col 0x10 A12=1 at cycle 10 → rd_en cycles 26..33, beat_col 0x10..0x17, beat_last at 33.
- RD col 0x06 A12=0 (BC4) → 4 beats, cols 6,7,4,5; then WRA col 0x08 → wr_en 8 beats starting CWL after the command; bank closes the cycle after beat_last.
- RD to a closed bank; cs_n=2'b00 with RANKS=2; ACT to an open bank → cmd_err one pulse each, open_mask unchanged.
- Two RDs 4 cycles apart, BL8 → first burst completes, second is dropped, cmd_err pulses at the second start. Two RDs 8 cycles apart → 16 contiguous rd_en beats.
- PRA rank1 with 5 banks open in rank1 and 2 in rank0 → rank1 bits all 0, rank0 bits intact. RDA completing plus ACT to the same bank in the same cycle → bank stays open.
- reset_n low at the 3rd beat of a read → all outputs 0 immediately, open_mask 0, no further beats after release.
